// File: rtl/jtagtrig.sv
// jtagtrig: two-stage pattern/edge trigger sequencer with occurrence counts and post-match delay driving the capture trigger
module jtagtrig #(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] indata,
  input  logic         wr,
  input  logic [7:0]   waddr,
  input  logic [15:0]  wdata,
  input  logic         arm,
  output logic         trigger,
  output logic [2:0]   state
);
  typedef enum logic [2:0] {IDLE = 3'd0, S0 = 3'd1, S1 = 3'd2, DLY = 3'd3, FIRE = 3'd4} state_t;
  state_t r_state, w_state_nx, w_exit;
  logic [15:0] r_cnt, w_cnt_nx, r_count0, r_count1, r_delay, w_need;
  logic r_ctrl, w_stg, w_hsel, w_done;
  logic [16:0] w_cnt1;
  logic [N-1:0] r_d, r_dp;
  logic [N-1:0] r_value [2];
  logic [N-1:0] r_mask [2];
  logic [N-1:0] r_edge [2];
  logic [1:0] w_hit;
  always_ff @(posedge clk)
    if (rst) begin
      r_d <= '0;
      r_dp <= '0;
      r_value <= '{'0, '0};
      r_mask <= '{'0, '0};
      r_edge <= '{'0, '0};
      r_count0 <= '0;
      r_count1 <= '0;
      r_delay <= '0;
      r_ctrl <= 1'b0;
    end else begin
      r_d <= indata;
      r_dp <= r_d;
      if (wr) begin
        for (int i = 0; i < N; i++)
          if (waddr[4:0] == i[8:4]) begin
            if (waddr[7:6] == 2'd0) r_value[waddr[5]][i] <= wdata[i[3:0]];
            if (waddr[7:6] == 2'd1) r_mask[waddr[5]][i] <= wdata[i[3:0]];
            if (waddr[7:6] == 2'd2) r_edge[waddr[5]][i] <= wdata[i[3:0]];
          end
        if (waddr == 8'hC0) r_count0 <= wdata;
        if (waddr == 8'hC1) r_count1 <= wdata;
        if (waddr == 8'hC2) r_delay <= wdata;
        if (waddr == 8'hC3) r_ctrl <= wdata[0];
      end
    end
  for (genvar g = 0; g < 2; g++) begin : g_hit
    assign w_hit[g] = &(~r_mask[g] | (~(r_d ^ r_value[g]) & (~r_edge[g] | (r_dp ^ r_value[g]))));
  end
  assign w_stg = r_state == S1;
  assign w_hsel = w_hit[w_stg];
  assign w_need = w_stg ? r_count1 : r_count0;
  assign w_cnt1 = {1'b0, r_cnt} + 17'd1;
  assign w_done = w_cnt1 >= {1'b0, w_need};
  assign w_exit = r_delay == '0 ? FIRE : DLY;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    if (arm) begin
      w_state_nx = S0;
      w_cnt_nx = '0;
    end else
      case (r_state)
        IDLE: w_state_nx = IDLE;
        S0, S1: if (w_hsel) begin
          w_cnt_nx = w_done ? '0 : w_cnt1[15:0];
          w_state_nx = !w_done ? r_state : (r_state == S0 && r_ctrl) ? S1 : w_exit;
        end
        DLY: begin
          w_cnt_nx = w_cnt1[15:0];
          w_state_nx = w_cnt1 >= {1'b0, r_delay} ? FIRE : DLY;
        end
        default: w_state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
    end
  assign trigger = r_state == FIRE;
  assign state = r_state;
endmodule

// File: tb/tb_jtagtrig.sv
// tb_jtagtrig: directed and randomized checks of jtagtrig (N=128 and N=20) against a behavioural model
module tb_jtagtrig;
  logic clk = 1'b0;
  logic rst, wr, arm;
  logic [7:0] waddr;
  logic [15:0] wdata;
  logic [127:0] indata;
  logic trig_a, trig_b;
  logic [2:0] st_a, st_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  jtagtrig #(.N(128)) u_a (.clk(clk), .rst(rst), .indata(indata), .wr(wr), .waddr(waddr),
    .wdata(wdata), .arm(arm), .trigger(trig_a), .state(st_a));
  jtagtrig #(.N(20)) u_b (.clk(clk), .rst(rst), .indata(indata[19:0]), .wr(wr), .waddr(waddr),
    .wdata(wdata), .arm(arm), .trigger(trig_b), .state(st_b));
  logic [511:0] mv [2];
  logic [511:0] mm [2];
  logic [511:0] me [2];
  logic [127:0] md, mdp;
  int mc0, mc1, mdl, mctl;
  int mst [2];
  int mcnt [2];
  function automatic int width(int u);
    return u == 0 ? 128 : 20;
  endfunction
  function automatic bit mhit(int s, int n);
    for (int i = 0; i < n; i++)
      if (mm[s][i] && (md[i] !== mv[s][i] || (me[s][i] && mdp[i] === mv[s][i]))) return 1'b0;
    return 1'b1;
  endfunction
  task automatic advance(int u, bit h0, bit h1);
    int need;
    if (arm) begin
      mst[u] = 1;
      mcnt[u] = 0;
      return;
    end
    case (mst[u])
      1, 2: begin
        need = mst[u] == 1 ? mc0 : mc1;
        if (need == 0) need = 1;
        if (mst[u] == 1 ? h0 : h1) begin
          if (mcnt[u] + 1 >= need) begin
            mcnt[u] = 0;
            if (mst[u] == 1 && mctl != 0) mst[u] = 2;
            else mst[u] = mdl == 0 ? 4 : 3;
          end else mcnt[u]++;
        end
      end
      3: if (mcnt[u] + 1 == mdl) mst[u] = 4; else mcnt[u]++;
      4: mst[u] = 0;
      default: ;
    endcase
  endtask
  task automatic model_edge();
    int idx;
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        mv[s] = '0;
        mm[s] = '0;
        me[s] = '0;
        mst[s] = 0;
        mcnt[s] = 0;
      end
      md = '0;
      mdp = '0;
      mc0 = 0;
      mc1 = 0;
      mdl = 0;
      mctl = 0;
      return;
    end
    for (int u = 0; u < 2; u++) advance(u, mhit(0, width(u)), mhit(1, width(u)));
    if (wr) begin
      if (waddr[7:6] != 2'd3)
        for (int j = 0; j < 16; j++) begin
          idx = int'(waddr[4:0]) * 16 + j;
          if (waddr[7:6] == 2'd0) mv[waddr[5]][idx] = wdata[j];
          if (waddr[7:6] == 2'd1) mm[waddr[5]][idx] = wdata[j];
          if (waddr[7:6] == 2'd2) me[waddr[5]][idx] = wdata[j];
        end
      else if (waddr == 8'hC0) mc0 = int'(wdata);
      else if (waddr == 8'hC1) mc1 = int'(wdata);
      else if (waddr == 8'hC2) mdl = int'(wdata);
      else if (waddr == 8'hC3) mctl = int'(wdata[0]);
    end
    mdp = md;
    md = indata;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("state_a", 16'(st_a), 16'(mst[0]));
    chk("trig_a", 16'(trig_a), 16'(mst[0] == 4));
    chk("state_b", 16'(st_b), 16'(mst[1]));
    chk("trig_b", 16'(trig_b), 16'(mst[1] == 4));
  endtask
  task automatic wreg(input logic [7:0] a, input logic [15:0] dat);
    wr = 1'b1;
    waddr = a;
    wdata = dat;
    tick();
    wr = 1'b0;
  endtask
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    int lat;
    int r;
    rst = 1'b1;
    wr = 1'b0;
    arm = 1'b0;
    waddr = '0;
    wdata = '0;
    indata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", 16'(st_a), 16'd0);
    chk("rst_trig", 16'(trig_a), 16'd0);
    do_arm();
    chk("arm_s0", 16'(st_a), 16'd1);
    tick();
    chk("noconf_fire_a", 16'(trig_a), 16'd1);
    chk("noconf_fire_b", 16'(trig_b), 16'd1);
    tick();
    chk("noconf_idle", 16'(st_a), 16'd0);
    do_rst();
    wreg(8'h40, 16'h00FF);
    wreg(8'h00, 16'h00A5);
    wreg(8'hC0, 16'd3);
    indata = rnd();
    indata[7:0] = 8'hA4;
    do_arm();
    repeat (12) begin
      indata = rnd();
      indata[7:0] = 8'hA4;
      tick();
    end
    chk("a4_nofire", 16'(st_a), 16'd1);
    for (int i = 0; i < 13; i++) begin
      indata = rnd();
      if (i == 3 || i == 7 || i == 12) indata[7:0] = 8'hA5;
      else while (indata[7:0] == 8'hA5) indata[7:0] = 8'($urandom);
      tick();
    end
    chk("a5_pending", 16'(trig_a), 16'd0);
    indata = rnd();
    indata[7:0] = 8'h5A;
    tick();
    chk("a5_third_a", 16'(trig_a), 16'd1);
    chk("a5_third_b", 16'(trig_b), 16'd1);
    do_rst();
    wreg(8'h40, 16'h0001);
    wreg(8'h00, 16'h0001);
    wreg(8'h80, 16'h0001);
    indata = rnd();
    indata[0] = 1'b0;
    tick();
    do_arm();
    indata = rnd();
    indata[0] = 1'b1;
    tick();
    indata = rnd();
    indata[0] = 1'b1;
    tick();
    chk("edge_fire", 16'(trig_a), 16'd1);
    repeat (3) tick();
    do_arm();
    repeat (8) begin
      indata = rnd();
      indata[0] = 1'b1;
      tick();
    end
    chk("edge_held", 16'(st_a), 16'd1);
    indata[0] = 1'b0;
    tick();
    indata[0] = 1'b1;
    tick();
    tick();
    chk("edge_refire", 16'(trig_a), 16'd1);
    do_rst();
    wreg(8'h40, 16'h000F);
    wreg(8'h00, 16'h0001);
    wreg(8'h60, 16'h000F);
    wreg(8'h20, 16'h0002);
    wreg(8'hC3, 16'h0001);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) wreg(8'hC2, 16'd5);
      indata = rnd();
      indata[3:0] = 4'h2;
      do_arm();
      repeat (3) tick();
      chk("two_first", 16'(st_a), 16'd1);
      indata[3:0] = 4'h1;
      tick();
      indata[3:0] = 4'h2;
      tick();
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        tick();
        if (trig_a === 1'b1) lat = c;
      end
      chk(k == 1 ? "dly5_lat" : "dly0_lat", 16'(lat), k == 1 ? 16'd6 : 16'd1);
    end
    do_rst();
    wreg(8'h40, 16'h000F);
    wreg(8'h00, 16'h0001);
    wreg(8'h60, 16'h000F);
    wreg(8'h20, 16'h0002);
    wreg(8'hC3, 16'h0001);
    wreg(8'hC1, 16'd5);
    wreg(8'hC2, 16'd3);
    indata = rnd();
    indata[3:0] = 4'h1;
    do_arm();
    indata[3:0] = 4'h2;
    repeat (3) tick();
    chk("s1_cnt2", 16'(st_a), 16'd2);
    do_arm();
    chk("rearm_s1", 16'(st_a), 16'd1);
    indata[3:0] = 4'h1;
    tick();
    indata[3:0] = 4'h2;
    tick();
    repeat (4) tick();
    chk("s1_restarted", 16'(st_a), 16'd2);
    tick();
    chk("in_dly", 16'(st_a), 16'd3);
    do_rst();
    chk("rst_dly_state", 16'(st_a), 16'd0);
    repeat (5) tick();
    chk("rst_dly_trig", 16'(trig_a), 16'd0);
    repeat (3) begin
      do_arm();
      tick();
      chk("cleared_fire", 16'(trig_a), 16'd1);
      tick();
    end
    do_rst();
    wreg(8'h41, 16'hFFFF);
    wreg(8'h01, 16'h000F);
    wreg(8'h42, 16'hFFFF);
    wreg(8'h02, 16'h1234);
    indata = rnd();
    indata[47:16] = 32'h0000_00FF;
    do_arm();
    tick();
    chk("n20_fire_b", 16'(trig_b), 16'd1);
    chk("n20_nofire_a", 16'(trig_a), 16'd0);
    tick();
    do_rst();
    repeat (3000) begin
      rst = $urandom_range(0, 299) == 0;
      arm = $urandom_range(0, 19) == 0;
      wr = $urandom_range(0, 5) == 0;
      r = $urandom_range(0, 3);
      if (r < 3) begin
        waddr = {2'(r), 1'($urandom), 5'($urandom_range(0, 2))};
        wdata = r == 0 ? 16'($urandom) : 16'($urandom & 32'h3);
      end else begin
        waddr = 8'hC0 + 8'($urandom_range(0, 4));
        wdata = 16'($urandom_range(0, 4));
      end
      indata = rnd();
      tick();
    end
    rst = 1'b0;
    arm = 1'b0;
    wr = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
